position_update_tracker: RTL and testbench



---
 rtl/position_update_tracker_pkg.sv | 19 +
 rtl/position_update_tracker_if.sv | 8 +
 rtl/position_update_tracker_pending.sv | 28 ++
 rtl/position_update_tracker.sv | 98 +++++++++
 tb/tb_position_update_tracker.sv | 115 +++++++++++
 5 files changed

// File: rtl/position_update_tracker_pkg.sv
// position_pkg: shared state encoding, target record and clamp helper for the position tracker.
`ifndef POS_X_BITS
`define POS_X_BITS 12
`endif
`ifndef POS_Y_BITS
`define POS_Y_BITS 12
`endif
package position_pkg;
  localparam int PX = `POS_X_BITS;
  localparam int PY = `POS_Y_BITS;
  typedef enum logic {IDLE, EMIT} state_t;
  typedef struct packed {
    logic [PX-1:0] x;
    logic [PY-1:0] y;
  } target_t;
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] m);
    return (v > m) ? m : v;
  endfunction
endpackage

// File: rtl/position_update_tracker_if.sv
// PositionUpdate_IF: absolute position command from the command processor.
interface PositionUpdate_IF #(parameter int XW = `POS_X_BITS, parameter int YW = `POS_Y_BITS);
  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic          update;
  modport master (output new_x, new_y, update);
  modport slave  (input new_x, new_y, update);
endinterface

// File: rtl/position_update_tracker_pending.sv
// pos_pending_buf: one-entry overwrite buffer holding the newest update that arrived during a move.
module pos_pending_buf import position_pkg::*; (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_load,
  input  logic    i_take,
  input  target_t i_data,
  output logic    o_valid,
  output target_t o_data,
  output logic    o_ovw
);
  logic    r_valid;
  target_t r_data;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovw   = i_load & r_valid & ~i_take;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/position_update_tracker.sv
// position_update_tracker: clamps absolute targets, emits signed per-axis deltas over valid/ready,
// and commits the position on handshake.
module position_update_tracker import position_pkg::*; #(
  parameter int POS_X_BITS = `POS_X_BITS,
  parameter int POS_Y_BITS = `POS_Y_BITS,
  parameter int X_MAX = 2**POS_X_BITS-1,
  parameter int Y_MAX = 2**POS_Y_BITS-1
) (
  input  logic                  clk,
  input  logic                  reset,
  PositionUpdate_IF.slave       pos_upd,
  output logic [POS_X_BITS-1:0] o_cur_x,
  output logic [POS_Y_BITS-1:0] o_cur_y,
  output logic [POS_X_BITS:0]   o_delta_x,
  output logic [POS_Y_BITS:0]   o_delta_y,
  output logic                  o_delta_valid,
  input  logic                  i_delta_ready,
  output logic                  o_busy,
  output logic                  o_clamped,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow
);
  state_t                r_state, w_next;
  target_t               r_cur, r_tgt, w_live, w_src, w_tc, w_pend;
  logic [POS_X_BITS:0]   r_dx;
  logic [POS_Y_BITS:0]   r_dy;
  logic                  r_clamped, r_ovf;
  logic                  w_pend_valid, w_pend_ovw, w_pend_load, w_pend_take;
  logic                  w_load, w_commit, w_drop, w_cx, w_cy;
  logic [31:0]           w_clx, w_cly;
  assign w_live = target_t'({pos_upd.new_x, pos_upd.new_y});
  assign w_src  = pos_upd.update ? w_live : w_pend;
  assign w_clx  = clamp(32'(w_src.x), 32'(X_MAX));
  assign w_cly  = clamp(32'(w_src.y), 32'(Y_MAX));
  assign w_cx   = w_clx != 32'(w_src.x);
  assign w_cy   = w_cly != 32'(w_src.y);
  assign w_tc   = target_t'({w_clx[POS_X_BITS-1:0], w_cly[POS_Y_BITS-1:0]});
  pos_pending_buf u_pend (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_pend_load),
    .i_take  (w_pend_take),
    .i_data  (w_live),
    .o_valid (w_pend_valid),
    .o_data  (w_pend),
    .o_ovw   (w_pend_ovw)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // In IDLE the pending entry is always consumed: either used as the source or dropped by a live update.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_pend_load = 1'b0;
    w_pend_take = 1'b0;
    w_drop      = 1'b0;
    if (r_state == IDLE) begin
      w_pend_take = w_pend_valid;
      w_drop      = pos_upd.update & w_pend_valid;
      w_load      = (pos_upd.update | w_pend_valid) & (w_tc != r_cur);
      w_next      = w_load ? EMIT : IDLE;
    end else begin
      w_pend_load = pos_upd.update;
      w_commit    = i_delta_ready;
      w_next      = i_delta_ready ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur     <= '0;
      r_tgt     <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_clamped <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_clamped <= w_load & (w_cx | w_cy);
      r_ovf     <= w_pend_ovw | w_drop | (r_ovf & ~i_clear_overflow);
      if (w_load) begin
        r_tgt <= w_tc;
        r_dx  <= {1'b0, w_tc.x} - {1'b0, r_cur.x};
        r_dy  <= {1'b0, w_tc.y} - {1'b0, r_cur.y};
      end
      if (w_commit) r_cur <= r_tgt;
    end
  end
  assign o_cur_x       = r_cur.x;
  assign o_cur_y       = r_cur.y;
  assign o_delta_x     = r_dx;
  assign o_delta_y     = r_dy;
  assign o_delta_valid = r_state == EMIT;
  assign o_busy        = (r_state == EMIT) | w_pend_valid;
  assign o_clamped     = r_clamped;
  assign o_overflow    = r_ovf;
endmodule

// File: tb/tb_position_update_tracker.sv
// tb_position_update_tracker: directed vector table plus hand sequences for pending, overflow and reset.
module tb_position_update_tracker;
  import position_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [11:0] cur_x, cur_y;
  logic [12:0] dx, dy;
  logic dv, ready = 1'b1, busy, clamped, ovf, clr = 1'b0;
  int checks = 0, errors = 0;
  PositionUpdate_IF #(.XW(12), .YW(12)) u_if ();
  position_update_tracker #(.POS_X_BITS(12), .POS_Y_BITS(12), .X_MAX(1000), .Y_MAX(4095)) dut (
    .clk(clk), .reset(reset), .pos_upd(u_if.slave),
    .o_cur_x(cur_x), .o_cur_y(cur_y), .o_delta_x(dx), .o_delta_y(dy),
    .o_delta_valid(dv), .i_delta_ready(ready), .o_busy(busy), .o_clamped(clamped),
    .o_overflow(ovf), .i_clear_overflow(clr)
  );
  always #5 clk = ~clk;
  typedef struct {
    int nx, ny, move, edx, edy, ecx, ecy, eclamp;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic upd(input int x, input int y);
    u_if.new_x = 12'(x);
    u_if.new_y = 12'(y);
    u_if.update = 1'b1;
    @(negedge clk);
    u_if.update = 1'b0;
  endtask
  initial begin
    u_if.new_x = '0;
    u_if.new_y = '0;
    u_if.update = 1'b0;
    v[0] = '{100, 50, 1, 100, 50, 100, 50, 0};
    v[1] = '{40, 80, 1, -60, 30, 40, 80, 0};
    v[2] = '{1500, 10, 1, 960, -70, 1000, 10, 1};
    v[3] = '{0, 4095, 1, -1000, 4085, 0, 4095, 0};
    v[4] = '{4095, 4095, 1, 1000, 0, 1000, 4095, 1};
    v[5] = '{5, 5, 1, -995, -4090, 5, 5, 0};
    v[6] = '{5, 5, 0, 0, 0, 5, 5, 0};
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_dv", dv, 0); chk("rst_cur_x", cur_x, 0); chk("rst_cur_y", cur_y, 0);
    chk("rst_dx", $signed(dx), 0); chk("rst_busy", busy, 0); chk("rst_clamped", clamped, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 7; i++) begin
      upd(v[i].nx, v[i].ny);
      chk($sformatf("v%0d_dv", i), dv, v[i].move);
      chk($sformatf("v%0d_busy", i), busy, v[i].move);
      if (v[i].move != 0) begin
        chk($sformatf("v%0d_dx", i), $signed(dx), v[i].edx);
        chk($sformatf("v%0d_dy", i), $signed(dy), v[i].edy);
        chk($sformatf("v%0d_clamped", i), clamped, v[i].eclamp);
        @(negedge clk);
        chk($sformatf("v%0d_dv_drop", i), dv, 0);
        chk($sformatf("v%0d_clamp_pulse", i), clamped, 0);
      end
      chk($sformatf("v%0d_cur_x", i), cur_x, v[i].ecx);
      chk($sformatf("v%0d_cur_y", i), cur_y, v[i].ecy);
    end
    ready = 1'b0;
    upd(10, 10);
    chk("hold_dv", dv, 1); chk("hold_dx", $signed(dx), 5);
    upd(30, 30);
    chk("pend_ovf0", ovf, 0); chk("pend_busy", busy, 1); chk("hold_dx2", $signed(dx), 5);
    upd(20, 20);
    chk("pend_ovf1", ovf, 1); chk("hold_dv2", dv, 1); chk("hold_dy3", $signed(dy), 5);
    chk("hold_cur", cur_x, 5);
    ready = 1'b1;
    @(negedge clk);
    chk("bub_cur_x", cur_x, 10); chk("bub_dv", dv, 0); chk("bub_busy", busy, 1);
    @(negedge clk);
    chk("pend_dv", dv, 1); chk("pend_dx", $signed(dx), 10); chk("pend_dy", $signed(dy), 10);
    @(negedge clk);
    chk("pend_cur_x", cur_x, 20); chk("pend_cur_y", cur_y, 20); chk("pend_idle_busy", busy, 0);
    upd(20, 20);
    chk("zero_dv", dv, 0); chk("zero_busy", busy, 0); chk("zero_cur", cur_x, 20);
    chk("ovf_sticky", ovf, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovf_clear", ovf, 0);
    ready = 1'b0;
    upd(100, 100);
    upd(200, 200);
    ready = 1'b1;
    @(negedge clk);
    chk("col_cur", cur_x, 100); chk("col_ovf0", ovf, 0);
    upd(300, 300);
    chk("col_dv", dv, 1); chk("col_dx", $signed(dx), 200); chk("col_ovf1", ovf, 1);
    @(negedge clk);
    chk("col_cur2", cur_y, 300); chk("col_busy", busy, 0); chk("col_dv0", dv, 0);
    ready = 1'b0;
    upd(50, 60);
    chk("ar_dv_pre", dv, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_dv", dv, 0); chk("ar_cur_x", cur_x, 0); chk("ar_cur_y", cur_y, 0);
    chk("ar_dx", $signed(dx), 0); chk("ar_busy", busy, 0); chk("ar_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk("post_dv", dv, 0); chk("post_cur", cur_x, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
